// File: rtl/fifo_read_master_pkg.sv
// rtl/fifo_read_master_pkg.sv - shared types and constants for the FIFO read master
//
// Purpose: state encoding for the read-master controller and its default
//          skid-buffer depth, imported by the top level and the skid buffer.
// Ports:   none (package).

package fifo_read_master_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN
    } rd_state_e;

    localparam int RD_SKID_DEPTH = 2;
    localparam int RD_FIFO_WIDTH = 16;

endpackage

// File: rtl/fifo_read_master_skid_buffer.sv
// rtl/fifo_read_master_skid_buffer.sv - circular skid buffer holding fetched FIFO words
//
// Purpose: DEPTH-entry circular buffer with wrap-around read/write pointers.
//          Push and pop in the same cycle leave the occupancy unchanged.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset (empties the buffer)
//   push, din   write strobe and data
//   pop         remove head entry (caller only pops when count != 0)
//   dout        head entry (meaningful only while count != 0)
//   count       current occupancy, 0..DEPTH

module fifo_read_master_skid_buffer
    import fifo_read_master_pkg::*;
#(
    parameter int WIDTH = RD_FIFO_WIDTH,
    parameter int DEPTH = RD_SKID_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            no_overflow: assert (!(push && !pop && count == CW'(DEPTH)));
            no_underrun: assert (!(pop && count == '0));
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_read_master.sv
// rtl/fifo_read_master.sv - read-side controller streaming FIFO words to a consumer
//
// Purpose: issues fifo_rd_en from the FIFO empty flag under a credit limit,
//          captures fifo_data_out one cycle later into a skid buffer and
//          presents it on a valid/ready stream. Counts delivered words and
//          keeps a sticky underflow error.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   enable           1 = fetch from FIFO, 0 = stop fetching and drain
//   fifo_rd_en       read strobe to the FIFO
//   fifo_data_out    FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty       FIFO empty flag
//   fifo_underflow   FIFO underflow indication
//   m_data, m_valid  stream data / valid (data forced to 0 while not valid)
//   m_ready          stream ready
//   rd_count         words delivered on the stream, wrapping
//   underflow_err    sticky underflow flag
//   busy             controller not idle

module fifo_read_master
    import fifo_read_master_pkg::*;
#(
    parameter int FIFO_WIDTH = RD_FIFO_WIDTH,
    parameter int SKID_DEPTH = RD_SKID_DEPTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err,
    output logic                  busy
);

    localparam int OCC_W = $clog2(SKID_DEPTH + 1);

    rd_state_e             state;
    rd_state_e             state_next;
    logic                  inflight;
    logic                  pop;
    logic [OCC_W-1:0]      occ;
    logic [FIFO_WIDTH-1:0] head;
    logic [OCC_W:0]        committed;
    logic                  credit_ok;

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? head : '0;

    // Slots already claimed after this cycle: buffered + in flight - leaving.
    // pop implies occ >= 1, so the subtraction cannot go negative.
    assign committed = {1'b0, occ} + (OCC_W+1)'(inflight) - (OCC_W+1)'(pop);
    assign credit_ok = (committed < (OCC_W+1)'(SKID_DEPTH));

    // Gated by rst_n so a reset cycle never pulls a word that would be discarded.
    assign fifo_rd_en = rst_n & (state == RD_RUN) & ~fifo_empty & credit_ok;

    fifo_read_master_skid_buffer #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (fifo_data_out),
        .pop   (pop),
        .dout  (head),
        .count (occ)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RD_IDLE;
            inflight      <= 1'b0;
            rd_count      <= '0;
            underflow_err <= 1'b0;
        end else begin
            state         <= state_next;
            inflight      <= fifo_rd_en;
            underflow_err <= underflow_err | fifo_underflow;
            if (pop) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != RD_IDLE);
        case (state)
            RD_IDLE:  if (enable) state_next = RD_RUN;
            RD_RUN:   if (!enable) state_next = RD_DRAIN;
            RD_DRAIN: begin
                if (enable) begin
                    state_next = RD_RUN;
                end else if (!inflight && occ == '0) begin
                    state_next = RD_IDLE;
                end
            end
            default:  state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            no_read_when_empty: assert (!(fifo_rd_en && fifo_empty));
        end
    end

endmodule
